// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: load-use bubbles, branch squash, memory-wait freeze with timeout trap.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] if_idRs,
    input  logic [4:0] if_idRt,
    input  logic       if_idUsesRt,
    input  logic       id_exMemRead,
    input  logic [4:0] id_exRt,
    input  logic       BranchTaken,
    input  logic       ex_memMemAccess,
    input  logic       MemAck,
    output logic       PCWrite,
    output logic       if_idWrite,
    output logic       if_idFlush,
    output logic       id_exFlush,
    output logic       PipeHold,
    output logic       MemReq,
    output logic       MemTimeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount
`endif
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_WIDTH < 1) begin : g_param_check
        $error("hazard_sequencer: MEM_TIMEOUT must be 1..255 and CNT_WIDTH >= 1");
    end

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StTrap
    } state_t;

    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       load_use;

    assign load_use = id_exMemRead && (id_exRt != 5'd0) &&
                      ((id_exRt == if_idRs) || (if_idUsesRt && (id_exRt == if_idRt)));

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        PCWrite    = 1'b0;
        if_idWrite = 1'b0;
        if_idFlush = 1'b0;
        id_exFlush = 1'b0;
        PipeHold   = 1'b0;
        MemReq     = 1'b0;
        MemTimeout = 1'b0;

        unique case (state_q)
            StRun: begin
                if (ex_memMemAccess && !MemAck) begin
                    PipeHold = 1'b1;
                    MemReq   = 1'b1;
                    state_d  = StMemWait;
                    wait_d   = 8'd1;
                end else begin
                    // Load-use beats branch: the branch re-resolves next cycle.
                    PCWrite    = !load_use;
                    if_idWrite = !load_use;
                    id_exFlush = load_use;
                    if_idFlush = BranchTaken && !load_use;
                    MemReq     = ex_memMemAccess;
                end
            end
            StMemWait: begin
                MemReq = 1'b1;
                if (MemAck) begin
                    PCWrite    = !load_use;
                    if_idWrite = !load_use;
                    id_exFlush = load_use;
                    if_idFlush = BranchTaken && !load_use;
                    state_d    = StRun;
                    wait_d     = 8'd0;
                end else begin
                    PipeHold = 1'b1;
                    wait_d   = 8'(wait_q + 8'd1);
                    if (wait_q == TimeoutVal) begin
                        state_d = StTrap;
                    end
                end
            end
            StTrap: begin
                PipeHold   = 1'b1;
                MemTimeout = 1'b1;
            end
            default: begin
                state_d = StRun;
                wait_d  = 8'd0;
            end
        endcase

        // Every output reads low while reset is asserted, independent of the clock.
        if (!Rst) begin
            PCWrite    = 1'b0;
            if_idWrite = 1'b0;
            if_idFlush = 1'b0;
            id_exFlush = 1'b0;
            PipeHold   = 1'b0;
            MemReq     = 1'b0;
            MemTimeout = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StRun;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q, flush_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PCWrite && (stall_q != {CNT_WIDTH{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if ((if_idFlush || id_exFlush) && (flush_q != {CNT_WIDTH{1'b1}})) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign StallCount = stall_q;
    assign FlushCount = flush_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_hazard_sequencer;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 32;

    logic       Clk;
    logic       Rst;
    logic [4:0] if_idRs, if_idRt, id_exRt;
    logic       if_idUsesRt, id_exMemRead, BranchTaken, ex_memMemAccess, MemAck;
    logic       PCWrite, if_idWrite, if_idFlush, id_exFlush, PipeHold, MemReq, MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] StallCount, FlushCount;
`endif

    hazard_sequencer #(
        .MEM_TIMEOUT(TO),
        .CNT_WIDTH  (CW)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .if_idRs        (if_idRs),
        .if_idRt        (if_idRt),
        .if_idUsesRt    (if_idUsesRt),
        .id_exMemRead   (id_exMemRead),
        .id_exRt        (id_exRt),
        .BranchTaken    (BranchTaken),
        .ex_memMemAccess(ex_memMemAccess),
        .MemAck         (MemAck),
        .PCWrite        (PCWrite),
        .if_idWrite     (if_idWrite),
        .if_idFlush     (if_idFlush),
        .id_exFlush     (id_exFlush),
        .PipeHold       (PipeHold),
        .MemReq         (MemReq),
        .MemTimeout     (MemTimeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCount     (StallCount),
        .FlushCount     (FlushCount)
`endif
    );

    // Output bundle order: PCWrite, if_idWrite, if_idFlush, id_exFlush, PipeHold, MemReq, MemTimeout
    logic [6:0] obs;
    assign obs = {PCWrite, if_idWrite, if_idFlush, id_exFlush, PipeHold, MemReq, MemTimeout};

    int total = 0;
    int bad   = 0;

    // Model: number of consecutive memory-held cycles so far, and whether we trapped.
    int    m_held;
    bit    m_trap;
    longint m_stall, m_flush;
    localparam longint CntMax = (longint'(1) << CW) - 1;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void model_reset();
        m_held  = 0;
        m_trap  = 1'b0;
        m_stall = 0;
        m_flush = 0;
    endfunction

    function automatic logic [6:0] model_out();
        bit lu, waiting, held, req;
        if (Rst !== 1'b1) return 7'b0;
        if (m_trap) return 7'b0000101;
        lu = id_exMemRead && (id_exRt != 0) &&
             ((id_exRt == if_idRs) || (if_idUsesRt && (id_exRt == if_idRt)));
        waiting = (m_held > 0);
        held = waiting ? !MemAck : (ex_memMemAccess && !MemAck);
        if (held) return 7'b0000110;
        req = waiting || ex_memMemAccess;
        if (lu) return {6'b000100, 1'b0} | {5'b0, req, 1'b0};
        if (BranchTaken) return {6'b111000, 1'b0} | {5'b0, req, 1'b0};
        return {6'b110000, 1'b0} | {5'b0, req, 1'b0};
    endfunction

    // Advance the model across a rising edge, using the inputs present before it.
    function automatic void model_step();
        logic [6:0] o;
        o = model_out();
        if (Rst !== 1'b1) begin
            model_reset();
            return;
        end
        if (!o[6] && m_stall < CntMax) m_stall++;
        if ((o[4] || o[3]) && m_flush < CntMax) m_flush++;
        if (m_trap) return;
        if (o == 7'b0000110) begin
            m_held++;
            if (m_held == int'(TO) + 1) m_trap = 1'b1;
        end else begin
            m_held = 0;
        end
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic quiet();
        if_idRs = 0; if_idRt = 0; if_idUsesRt = 0; id_exMemRead = 0; id_exRt = 0;
        BranchTaken = 0; ex_memMemAccess = 0; MemAck = 0;
    endtask

    task automatic rand_inputs();
        if_idRs         = 5'($urandom_range(0, 3));
        if_idRt         = 5'($urandom_range(0, 3));
        id_exRt         = 5'($urandom_range(0, 3));
        if_idUsesRt     = 1'($urandom);
        id_exMemRead    = 1'($urandom);
        BranchTaken     = 1'($urandom);
        ex_memMemAccess = 1'($urandom);
        MemAck          = 1'($urandom);
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            rand_inputs();
            #2;
            total++;
            if (obs !== 7'b0) begin
                bad++;
                $display("FAIL reset_outputs: got %b want 0000000", obs);
            end
            tick();
        end
        quiet();
        Rst = 1'b1;
        #2;
        total++;
        if (obs !== 7'b1100000) begin
            bad++;
            $display("FAIL reset_release: got %b want 1100000", obs);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [6:0] want [4];
        want[0] = 7'b0001000; want[1] = 7'b1100000; want[2] = 7'b1100000; want[3] = 7'b0001000;
        for (int i = 0; i < 4; i++) begin
            quiet();
            case (i)
                0: begin id_exMemRead = 1; id_exRt = 8; if_idRs = 8; end
                1: ;
                2: begin id_exMemRead = 1; id_exRt = 0; if_idRs = 0; end
                default: begin id_exMemRead = 1; id_exRt = 8; if_idRs = 3;
                    if_idUsesRt = 1; if_idRt = 8; end
            endcase
            #2;
            total++;
            if (obs !== want[i]) begin
                bad++;
                $display("FAIL load_use_%0d: got %b want %b", i, obs, want[i]);
            end
            tick();
        end
        quiet();
        id_exMemRead = 1; id_exRt = 8; if_idRs = 3; if_idRt = 8; if_idUsesRt = 0;
        #2;
        total++;
        if (obs !== 7'b1100000) begin
            bad++;
            $display("FAIL load_use_rt_unused: got %b want 1100000", obs);
        end
        tick();
    endtask

    task automatic test_branch_load_use();
        quiet();
        BranchTaken = 1; id_exMemRead = 1; id_exRt = 5; if_idRs = 5;
        #2;
        total++;
        if (obs !== 7'b0001000) begin
            bad++;
            $display("FAIL branch_lu_first: got %b want 0001000", obs);
        end
        tick();
        id_exMemRead = 0;
        #2;
        total++;
        if (obs !== 7'b1110000) begin
            bad++;
            $display("FAIL branch_lu_second: got %b want 1110000", obs);
        end
        tick();
        quiet();
    endtask

    task automatic test_mem3();
        logic [6:0] want [4];
        want[0] = 7'b0000110; want[1] = 7'b0000110; want[2] = 7'b1100010; want[3] = 7'b1100000;
        for (int i = 0; i < 4; i++) begin
            quiet();
            ex_memMemAccess = (i < 3);
            MemAck = (i == 2);
            #2;
            total++;
            if (obs !== want[i]) begin
                bad++;
                $display("FAIL mem3_cycle%0d: got %b want %b", i, obs, want[i]);
            end
            tick();
        end
        quiet();
        ex_memMemAccess = 1; MemAck = 1;
        #2;
        total++;
        if (obs !== 7'b1100010) begin
            bad++;
            $display("FAIL mem_zero_wait: got %b want 1100010", obs);
        end
        tick();
        quiet();
    endtask

    task automatic test_timeout();
        logic [6:0] want;
        for (int i = 0; i < 9; i++) begin
            rand_inputs();
            MemAck = 0;
            ex_memMemAccess = (i < 5) ? 1'b1 : 1'($urandom);
            want = (i < 5) ? 7'b0000110 : 7'b0000101;
            #2;
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL timeout_cycle%0d: got %b want %b", i, obs, want);
            end
            tick();
        end
        Rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL timeout_async_reset: got %b want 0000000", obs);
        end
        quiet();
        #1;
        Rst = 1'b1;
        #1;
        total++;
        if (obs !== 7'b1100000) begin
            bad++;
            $display("FAIL timeout_cleared: got %b want 1100000", obs);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] exp;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                Rst = 1'b0;
                model_reset();
            end else begin
                Rst = 1'b1;
            end
            rand_inputs();
            if ($urandom_range(0, 3) == 0) MemAck = 0;
            #2;
            exp = model_out();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL random_cycle%0d: got %b want %b", i, obs, exp);
            end
            tick();
        end
        Rst = 1'b1;
        quiet();
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (StallCount !== CW'(m_stall) || FlushCount !== CW'(m_flush)) begin
            bad++;
            $display("FAIL random_perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     StallCount, FlushCount, m_stall, m_flush);
        end
`endif
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        quiet();
        Rst = 1'b0;
        model_reset();
        #2;
        Rst = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            quiet();
            if (i == 0 || i == 2) begin id_exMemRead = 1; id_exRt = 9; if_idRs = 9; end
            if (i == 4) BranchTaken = 1;
            tick();
        end
        #2;
        total++;
        if (StallCount !== 2 || FlushCount !== 3) begin
            bad++;
            $display("FAIL perf_counts: got stall=%0d flush=%0d want stall=2 flush=3",
                     StallCount, FlushCount);
        end
    endtask
`endif

    initial begin
        Rst = 1'b0;
        quiet();
        model_reset();
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem3();
        test_timeout();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
